// File: rtl/cpu_pkg.sv
// Constants and types shared by the sequencer, pc, decode and execute stages.
package cpu_pkg;

  typedef logic [2:0] cycle_t;

  localparam cycle_t LAST_CYCLE = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } seq_state_t;

  // States in which the sequencer issues CPU ticks.
  function automatic logic is_active(input seq_state_t s);
    return (s == RUN) || (s == STEP);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
// btnLevel follows the synchronized input after DEB_CYCLES equal samples; btnRise pulses with it.
module btn_debounce #(
  parameter int DEB_CYCLES = 270_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btnRaw,
  output logic btnLevel,
  output logic btnRise
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differs;
  logic             w_settled;

  assign w_differs = (r_sync2 != r_level);
  // The DEB_CYCLES-th consecutive differing sample flips the level.
  assign w_settled = w_differs && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync1 <= btnRaw;
      r_sync2 <= r_sync1;
      if (!w_differs || w_settled) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_settled) begin
        r_level <= r_sync2;
      end
      r_rise <= w_settled && r_sync2;
    end
  end

  assign btnLevel = r_level;
  assign btnRise  = r_rise;

endmodule

// File: rtl/cycle_gen.sv
// Instruction-cycle sequencer: prescaled CPU clock-enable, 3-bit micro-cycle index and
// run/step/halt control that only ever stops on an instruction boundary.
module cycle_gen
  import cpu_pkg::*;
#(
  parameter int CLK_DIV    = 13_500_000,
  parameter int DEB_CYCLES = 270_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       stepReq,
  input  logic       halt,
  output logic       cpuCe,
  output cycle_t     cycle,
  output logic       instrDone,
  output logic [1:0] state
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic             r_run_s1;
  logic             r_run_s2;
  logic [DIV_W-1:0] r_div_cnt;
  cycle_t           r_cycle;
  seq_state_t       r_state;
  seq_state_t       w_state_nxt;
  logic             r_cpu_ce;
  logic             w_cpu_ce_nxt;
  logic             w_tick;
  logic             w_boundary;
  logic             w_step_level;
  logic             w_step_rise;
  logic             w_step_pulse;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_step_btn (
    .clk      (clk),
    .reset    (reset),
    .btnRaw   (stepReq),
    .btnLevel (w_step_level),
    .btnRise  (w_step_rise)
  );

  assign w_step_pulse = w_step_rise && w_step_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_s1 <= 1'b0;
      r_run_s2 <= 1'b0;
    end else begin
      r_run_s1 <= run;
      r_run_s2 <= r_run_s1;
    end
  end

  // Free-running prescaler, independent of sequencer state.
  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle <= '0;
    end else if (r_cpu_ce) begin
      r_cycle <= r_cycle + 1'b1;
    end
  end

  assign w_boundary = r_cpu_ce && (r_cycle == LAST_CYCLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_run_s2) begin
          w_state_nxt = RUN;
        end else if (w_step_pulse) begin
          w_state_nxt = STEP;
        end
      end
      RUN: begin
        if (w_boundary) begin
          if (halt) begin
            w_state_nxt = HALTED;
          end else if (!r_run_s2) begin
            w_state_nxt = IDLE;
          end
        end
      end
      STEP: begin
        if (w_boundary) begin
          w_state_nxt = halt ? HALTED : IDLE;
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Gating on the next state suppresses a tick in the clk after leaving RUN/STEP.
    w_cpu_ce_nxt = w_tick && is_active(w_state_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cpu_ce <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_ce <= w_cpu_ce_nxt;
    end
  end

  assign cpuCe     = r_cpu_ce;
  assign cycle     = r_cycle;
  assign instrDone = w_boundary;
  assign state     = r_state;

endmodule

// File: tb/tb_cycle_gen.sv
// Bench for cycle_gen with CLK_DIV=4, DEB_CYCLES=3: directed scenarios plus random lockstep model.
module tb_cycle_gen;

  localparam int CLK_DIV = 4;
  localparam int DEB     = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       stepReq;
  logic       halt;
  logic       cpuCe;
  logic [2:0] cycle;
  logic       instrDone;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  cycle_gen #(
    .CLK_DIV    (CLK_DIV),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .stepReq   (stepReq),
    .halt      (halt),
    .cpuCe     (cpuCe),
    .cycle     (cycle),
    .instrDone (instrDone),
    .state     (state)
  );

  always #5 clk = ~clk;

  // Reference model: clk count since reset drives the prescaler, inputs delayed by sample history.
  int m_clks = 0;
  int m_cycle = 0;
  int m_state = 0;
  int m_diff_run = 0;
  bit m_ce = 0, m_run1 = 0, m_run2 = 0, m_b1 = 0, m_b2 = 0, m_lvl = 0, m_pulse = 0;
  bit m_tick, m_bnd, m_settle;
  int m_nxt;

  function automatic int model_next(int st, bit bnd, bit run_s, bit pulse, bit hlt);
    case (st)
      0:       return run_s ? 1 : (pulse ? 2 : 0);
      1:       return !bnd ? 1 : (hlt ? 3 : (run_s ? 1 : 0));
      2:       return !bnd ? 2 : (hlt ? 3 : 0);
      default: return 3;
    endcase
  endfunction

  always_comb begin
    m_tick   = ((m_clks % CLK_DIV) == CLK_DIV - 1);
    m_bnd    = m_ce && (m_cycle == 7);
    m_settle = (m_b2 != m_lvl) && (m_diff_run + 1 == DEB);
    m_nxt    = model_next(m_state, m_bnd, m_run2, m_pulse, halt);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_clks <= 0; m_cycle <= 0; m_state <= 0; m_diff_run <= 0;
      m_ce <= 0; m_run1 <= 0; m_run2 <= 0; m_b1 <= 0; m_b2 <= 0; m_lvl <= 0; m_pulse <= 0;
    end else begin
      m_clks   <= m_clks + 1;
      m_run1   <= run;
      m_run2   <= m_run1;
      m_b1     <= stepReq;
      m_b2     <= m_b1;
      m_diff_run <= (m_b2 == m_lvl || m_settle) ? 0 : m_diff_run + 1;
      if (m_settle) m_lvl <= m_b2;
      m_pulse  <= m_settle && m_b2;
      if (m_ce) m_cycle <= (m_cycle + 1) % 8;
      m_state  <= m_nxt;
      m_ce     <= m_tick && (m_nxt == 1 || m_nxt == 2);
    end
  end

  function automatic logic [6:0] dut_vec();
    return {state, cycle, cpuCe, instrDone};
  endfunction

  function automatic logic [6:0] model_vec();
    return {2'(m_state), 3'(m_cycle), m_ce, m_ce && (m_cycle == 7)};
  endfunction

  task automatic test_reset();
    int ce_cnt = 0;
    int bad = 0;
    reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++; $display("FAIL reset_values: got %b required 0000000", dut_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpuCe === 1'b1) ce_cnt++;
      if (cycle !== 3'd0 || state !== 2'd0) bad++;
    end
    checks++;
    if (ce_cnt != 0) begin
      errors++; $display("FAIL idle_no_ce: got %0d pulses required 0", ce_cnt);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_hold: got %0d bad clks required 0", bad);
    end
  endtask

  task automatic test_run();
    int n = 0;
    int last_ce = -1, last_done = -1, exp_cyc = 0;
    int ce_cnt = 0, done_cnt = 0, bad_int = 0, bad_seq = 0, bad_done = 0, bad_dint = 0;
    run = 1'b1;
    while (state !== 2'd1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL run_entry_latency: got %0d clk required 3", n);
    end
    for (int t = 0; t < 260; t++) begin
      @(negedge clk);
      if (instrDone !== (cpuCe === 1'b1 && cycle === 3'd7)) bad_done++;
      if (cpuCe === 1'b1) begin
        ce_cnt++;
        if (last_ce >= 0 && t - last_ce != CLK_DIV) bad_int++;
        if (cycle !== 3'(exp_cyc)) bad_seq++;
        exp_cyc = (exp_cyc + 1) % 8;
        last_ce = t;
      end
      if (instrDone === 1'b1) begin
        if (last_done >= 0 && t - last_done != 8 * CLK_DIV) bad_dint++;
        done_cnt++;
        last_done = t;
      end
    end
    checks++;
    if (ce_cnt != 65) begin
      errors++; $display("FAIL run_ce_count: got %0d required 65", ce_cnt);
    end
    checks++;
    if (bad_int != 0) begin
      errors++; $display("FAIL run_ce_interval: got %0d bad intervals required 0", bad_int);
    end
    checks++;
    if (bad_seq != 0) begin
      errors++; $display("FAIL run_cycle_seq: got %0d out-of-order cycles required 0", bad_seq);
    end
    checks++;
    if (bad_done != 0 || bad_dint != 0 || done_cnt < 8 || done_cnt > 9) begin
      errors++; $display("FAIL run_instr_done: got mismatch=%0d badint=%0d count=%0d required 0,0,8..9", bad_done, bad_dint, done_cnt);
    end
    run = 1'b0;
    n = 0;
    while (state !== 2'd0 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (state !== 2'd0 || cycle !== 3'd0) begin
      errors++; $display("FAIL run_stop_idle: got state=%0d cycle=%0d required 0,0", state, cycle);
    end
  endtask

  task automatic test_step();
    int bad = 0, n = 0, ce_cnt = 0, done_cnt = 0, entries = 0;
    logic [1:0] prev;
    for (int g = 0; g < 4; g++) begin
      stepReq = 1'b1;
      @(negedge clk);
      stepReq = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (state !== 2'd0 || cpuCe !== 1'b0) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL step_glitch_ignored: got %0d active clks required 0", bad);
    end
    stepReq = 1'b1;
    while (state !== 2'd2 && n < 20) begin
      @(negedge clk); n++;
      if (cpuCe === 1'b1) ce_cnt++;
    end
    checks++;
    if (n != DEB + 3) begin
      errors++; $display("FAIL step_accept_latency: got %0d clk required %0d", n, DEB + 3);
    end
    prev = state;
    for (int k = n + 1; k <= 120; k++) begin
      stepReq = (k <= 10) || (k >= 16 && k <= 23);
      @(negedge clk);
      if (cpuCe === 1'b1) ce_cnt++;
      if (instrDone === 1'b1) done_cnt++;
      if (prev === 2'd0 && state === 2'd2) entries++;
      prev = state;
    end
    stepReq = 1'b0;
    checks++;
    if (ce_cnt != 8 || done_cnt != 1) begin
      errors++; $display("FAIL step_one_instr: got ce=%0d done=%0d required 8,1", ce_cnt, done_cnt);
    end
    checks++;
    if (entries != 0) begin
      errors++; $display("FAIL step_second_press: got %0d re-entries required 0", entries);
    end
    checks++;
    if (state !== 2'd0 || cycle !== 3'd0) begin
      errors++; $display("FAIL step_end_idle: got state=%0d cycle=%0d required 0,0", state, cycle);
    end
  endtask

  task automatic test_halt();
    int n = 0, bad = 0, seen3 = 0;
    logic prev_done = 1'b0;
    logic done_before = 1'b0;
    run = 1'b1;
    while (state !== 2'd1 && n < 20) begin
      @(negedge clk); n++;
    end
    for (int i = 0; i < 100; i++) begin
      halt = (cycle === 3'd3);
      @(negedge clk);
      if (state !== 2'd1) bad++;
      if (cpuCe === 1'b1 && cycle === 3'd3) seen3++;
    end
    halt = 1'b0;
    checks++;
    if (bad != 0 || seen3 == 0) begin
      errors++; $display("FAIL halt_mid_ignored: got %0d non-run clks, %0d cycle3 ticks required 0,>0", bad, seen3);
    end
    n = 0;
    while (state !== 2'd3 && n < 80) begin
      halt = (cycle === 3'd7);
      prev_done = instrDone;
      @(negedge clk); n++;
    end
    done_before = prev_done;
    halt = 1'b0;
    checks++;
    if (state !== 2'd3 || cycle !== 3'd0 || done_before !== 1'b1) begin
      errors++; $display("FAIL halt_enter: got state=%0d cycle=%0d done_before=%b required 3,0,1", state, cycle, done_before);
    end
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      run = (i >= 20 && i < 40);
      stepReq = (i >= 5 && i < 15) || (i >= 45);
      @(negedge clk);
      if (state !== 2'd3 || cpuCe !== 1'b0 || cycle !== 3'd0) bad++;
    end
    run = 1'b0;
    stepReq = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_absorbing: got %0d escaped clks required 0", bad);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (state !== 2'd0) begin
      errors++; $display("FAIL halt_reset_exit: got state=%0d required 0", state);
    end
  endtask

  task automatic test_run_drop();
    int n = 0, ce_cnt = 0, k_done = -1, k_idle = -1, bad = 0, ce_max = -1;
    run = 1'b1;
    while (!(state === 2'd1 && cycle === 3'd2) && n < 120) begin
      @(negedge clk); n++;
    end
    run = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cpuCe === 1'b1) begin
        ce_cnt++;
        ce_max = int'(cycle);
      end
      if (instrDone === 1'b1 && k_done < 0) k_done = k;
      if (state === 2'd0) begin
        k_idle = k;
        break;
      end
    end
    checks++;
    if (ce_cnt != 6 || ce_max != 7) begin
      errors++; $display("FAIL drop_completes: got %0d ticks last cycle %0d required 6,7", ce_cnt, ce_max);
    end
    checks++;
    if (k_done < 0 || k_idle != k_done + 1) begin
      errors++; $display("FAIL drop_idle_at_boundary: got done@%0d idle@%0d required idle=done+1", k_done, k_idle);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpuCe !== 1'b0 || cycle !== 3'd0 || state !== 2'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL drop_quiet: got %0d active clks required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    run = 1'b1;
    while (!(state === 2'd1 && cycle === 3'd5) && n < 120) begin
      @(negedge clk); n++;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dut_vec() !== 7'b0) begin
      errors++; $display("FAIL reset_async_mid: got %b required 0000000", dut_vec());
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (state !== 2'd1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL reset_reenter_run: got %0d clk required 3", n);
    end
    run = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_random();
    int hold_left = 0;
    int bad = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if (hold_left == 0) begin
        stepReq = 1'($urandom_range(0, 1));
        hold_left = $urandom_range(1, 12);
      end else begin
        hold_left--;
      end
      halt  = ($urandom_range(0, 99) < 4);
      reset = ($urandom_range(0, 249) == 0);
      @(negedge clk);
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        bad++;
        $display("FAIL random_model: clk %0d got {state,cycle,ce,done}=%b required %b", i, dut_vec(), model_vec());
      end
    end
    reset = 1'b0;
    halt = 1'b0;
    run = 1'b0;
    stepReq = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    run     = 1'b0;
    stepReq = 1'b0;
    halt    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_run();
    test_step();
    test_halt();
    test_run_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cycle_gen.md
# cycle_gen

Instruction-cycle sequencer directly upstream of the program counter. Divides the board clock into a one-`clk`-wide CPU clock-enable (`cpuCe`) and a 3-bit micro-cycle index (`cycle`, 0..7). Provides free-run, single-instruction step and halt control, always stopping on an instruction boundary. `pc`, decode and execute stages all qualify their updates with `cpuCe` and `cycle`.

## Interface
- `CLK_DIV`, default 13_500_000: `clk` periods per CPU tick. Legal range ≥1; 1 means a tick on every `clk`.
- `DEB_CYCLES`, default 270_000: `clk` periods `stepReq` must be stable to be accepted. Legal range ≥1.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `run` in 1: asynchronous level; 1 = free-run.
- `stepReq` in 1: raw push-button; each accepted press executes one instruction.
- `halt` in 1: HLT request from decode. Valid while `cycle` = 7.
- `cpuCe` out 1: registered; one-`clk` pulse per CPU tick.
- `cycle` out 3: micro-cycle index. Consumers sample it while `cpuCe` = 1.
- `instrDone` out 1: high exactly when `cpuCe` = 1 and `cycle` = 7. This is the same `clk` in which `pc` updates.
- `state` out 2: IDLE=0, RUN=1, STEP=2, HALTED=3.

## Operation
- `run` passes through a 2-flop synchronizer.
- `stepReq` passes through a 2-flop synchronizer, then the debouncer. It becomes `stepPulse`, one `clk` wide, on a debounced 0→1 transition only.
- Prescaler `divCnt` counts 0..CLK_DIV-1 and wraps.
  - It runs in every state.
  - `tick` = (`divCnt` = CLK_DIV-1).
- `cycle` increments by 1 on each `clk` edge where `cpuCe` = 1. It wraps 7→0 using 3-bit modulo arithmetic. It never changes otherwise.
- State machine. Boundary = `cpuCe` = 1 and `cycle` = 7.
  - IDLE → RUN if synchronized `run` = 1. Else IDLE → STEP if `stepPulse` = 1. `run` has priority over `stepPulse`.
  - RUN, at a boundary:
    - `halt` = 1 → HALTED.
    - Else synchronized `run` = 0 → IDLE.
    - Else stay in RUN.
    - No transition away from RUN occurs at any other time.
  - STEP, at a boundary: `halt` = 1 → HALTED; else → IDLE.
  - HALTED: absorbing; only `reset` exits.
- `cpuCe` next value = `tick` AND (next state ∈ {RUN, STEP}). Because of this gating, no `cpuCe` pulse is issued in the `clk` after a boundary that leaves RUN/STEP, even when CLK_DIV=1.
- IDLE and HALTED are always entered with `cycle` = 0 and stay at 0.
- `stepPulse` outside IDLE is discarded, not queued.
- `halt` is ignored except at a boundary.
- Reset values: `divCnt`=0, `cycle`=0, `state`=IDLE, `cpuCe`=0, `instrDone`=0. Synchronizers, debounce counter and debounced level are all 0.

## Timing
- Steady RUN: one `cpuCe` every CLK_DIV `clk`; one instruction every 8×CLK_DIV `clk`.
- `run` rise to state RUN: 3 `clk` (2 sync + 1 state). First `cpuCe` follows the next `tick`, at most CLK_DIV+1 `clk` later.
- `stepReq` acceptance:
  - Debounced level updates after DEB_CYCLES consecutive equal synchronized samples.
  - A sample differing from the debounced level restarts the counter.
  - `stepPulse` fires 2 + DEB_CYCLES `clk` after a clean press.
- Reset mid-instruction: outputs return to reset values asynchronously. The partially executed instruction is abandoned.
- `run` dropped mid-instruction: the instruction completes through `cycle` = 7; the sequencer then enters IDLE.
- `run` and `halt` both active at a boundary: HALTED.

## Structure
- Shared package `cpu_pkg`:
  - `cycle_t` (3 bits) and `LAST_CYCLE` = 7.
  - `seq_state_t` enum (IDLE/RUN/STEP/HALTED, encoded as above).
  - `pc`, decode and execute import the same constants.
- One sub-module, `btn_debounce` (parameter DEB_CYCLES):
  - Ports: `clk`, `reset`, `btnRaw` → `btnLevel`, `btnRise`.
  - Contains the 2-flop synchronizer, the stability counter (width $clog2(DEB_CYCLES+1)) and the edge detector.
- Prescaler width is $clog2(CLK_DIV) with a minimum of 1.

## Test plan
All scenarios use CLK_DIV=4, DEB_CYCLES=3.
- Reset released, `run`=0, no button, 200 `clk` → `cpuCe` never 1, `cycle`=0, `state`=0.
- `run`=1 held for 260 `clk` after `state` enters 1 → `cpuCe` every 4 `clk` and `cycle` sequence 0,1,…,7,0. `instrDone` coincides with `cpuCe` at `cycle`=7, once per 32 `clk`.
- `stepReq` with 1-`clk` glitches, then held 10 `clk` →
  - Glitches produce no pulse.
  - The held press produces exactly 8 `cpuCe` and 1 `instrDone`, then `state`=0, `cycle`=0.
  - A second press while `state`=2 has no effect.
- In RUN, `halt`=1 only during `cycle`=3 → keeps running. `halt`=1 during `cycle`=7 → `state`=3, no further `cpuCe`. `run`/`stepReq` then have no effect until `reset`.
- In RUN, `run` deasserted at `cycle`=2 → `cycle` continues 3..7, then `state`=0. No `cpuCe` after that boundary, `cycle` stays 0.
- `reset` pulsed while `cycle`=5 in RUN → immediately `cycle`=0, `cpuCe`=0, `instrDone`=0, `state`=0. With `run` still 1, RUN is re-entered 3 `clk` after reset release.
